shift_exec_unit: RTL



---
 rtl/shift_exec_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: holds a shift request stable for SETTLE_CYCLES, then captures the selected SHL/SLR/SAR/ROR result.
// Optional feature macro SHIFT_FLAGS_EN enables the registered zero/carry flags.
module shift_exec_unit #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  amount,
  input  logic [31:0] entry,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        zero,
  output logic        carry
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic [4:0]  r_amount;
  logic [31:0] r_entry, r_out;
  logic [31:0] w_shl, w_slr, w_sar, w_ror, w_res;
  logic        w_cap;
  assign w_shl = r_entry << r_amount;
  assign w_slr = r_entry >> r_amount;
  assign w_sar = $signed(r_entry) >>> r_amount;
  // A shift by 32 yields 0, so amount 0 leaves the operand intact.
  assign w_ror = (r_entry >> r_amount) | (r_entry << (6'd32 - {1'b0, r_amount}));
  assign w_res = r_op[1] ? (r_op[0] ? w_ror : w_sar) : (r_op[0] ? w_slr : w_shl);
  assign w_cap = (r_state == SETTLE) && (r_cnt == 4'd0);
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign out   = r_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? SETTLE : IDLE;
      SETTLE:  w_next = w_cap ? DONE : SETTLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_op     <= 2'd0;
      r_amount <= 5'd0;
      r_entry  <= 32'd0;
      r_out    <= 32'd0;
    end else begin
      if (r_state == IDLE && start) begin
        r_op     <= op;
        r_amount <= amount;
        r_entry  <= entry;
        r_cnt    <= 4'(SETTLE_CYCLES - 1);
      end else if (r_state == SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_cap) r_out <= w_res;
    end
  end
`ifdef SHIFT_FLAGS_EN
  logic r_zero, r_carry, w_carry;
  // SHL carry is entry[32-n]; modulo-32 that index is simply -n.
  assign w_carry = (r_op == 2'b00) ? r_entry[5'd0 - r_amount] :
                   (r_op == 2'b11) ? w_ror[31] : r_entry[r_amount - 5'd1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_cap) begin
      r_zero <= (w_res == 32'd0);
      if (r_amount != 5'd0) r_carry <= w_carry;
    end
  end
  assign zero  = r_zero;
  assign carry = r_carry;
`else
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif
endmodule
